// File: rtl/serial_deser_if.sv
// Serial deserializer bus: serial line in, received word plus status pulses out.
// The consumer drives the line (master); the deserializer owns the results (slave).
interface serial_deser_if #(
    parameter int DATA_W = 8
);
    logic              in;
    logic [DATA_W-1:0] out_byte;
    logic              done;
    logic              frame_err;
    logic              busy;

    modport master (
        output in,
        input  out_byte,
        input  done,
        input  frame_err,
        input  busy
    );

    modport slave (
        input  in,
        output out_byte,
        output done,
        output frame_err,
        output busy
    );
endinterface

// File: rtl/serial_deser.sv
// Start/data/stop serial frame deserializer, one bit per clock, LSB first.
// Define SERIAL_DESER_PARITY_EN to add an odd-parity bit between data and stop.
module serial_deser #(
    parameter int DATA_W = 8
) (
    input  logic          clk,
    input  logic          reset,
    serial_deser_if.slave bus
);
    localparam int CW = $clog2(DATA_W) + 1;

    typedef enum logic [2:0] {
        IDLE,
        DATA,
`ifdef SERIAL_DESER_PARITY_EN
        PARITY,
`endif
        STOP,
        DONE,
`ifdef SERIAL_DESER_PARITY_EN
        ERR,
`endif
        WAIT
    } state_t;

    state_t            r_state;
    logic [CW-1:0]     r_cnt;
    logic [DATA_W-1:0] r_shift;
    logic [DATA_W-1:0] r_out;
    logic              r_done;
    logic              r_err;
    logic              r_busy;
`ifdef SERIAL_DESER_PARITY_EN
    logic              r_par;
`endif

    // Outputs are registered alongside the state so they line up with it.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_shift <= '0;
            r_out   <= '0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
            r_busy  <= 1'b0;
`ifdef SERIAL_DESER_PARITY_EN
            r_par   <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (!bus.in) begin
                        r_state <= DATA;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
`ifdef SERIAL_DESER_PARITY_EN
                        r_par   <= 1'b0;
`endif
                    end
                end
                DATA: begin
                    r_shift <= {bus.in, r_shift[DATA_W-1:1]};
                    r_cnt   <= r_cnt + 1'b1;
`ifdef SERIAL_DESER_PARITY_EN
                    r_par   <= r_par ^ bus.in;
`endif
                    if (r_cnt == CW'(DATA_W - 1)) begin
`ifdef SERIAL_DESER_PARITY_EN
                        r_state <= PARITY;
`else
                        r_state <= STOP;
`endif
                    end
                end
`ifdef SERIAL_DESER_PARITY_EN
                PARITY: begin
                    r_par   <= r_par ^ bus.in;
                    r_state <= STOP;
                end
`endif
                STOP: begin
                    r_busy <= 1'b0;
                    if (!bus.in) begin
                        r_state <= WAIT;
                        r_err   <= 1'b1;
`ifdef SERIAL_DESER_PARITY_EN
                    end else if (!r_par) begin
                        r_state <= ERR;
                        r_err   <= 1'b1;
`endif
                    end else begin
                        r_state <= DONE;
                        r_done  <= 1'b1;
                        r_out   <= r_shift;
                    end
                end
`ifdef SERIAL_DESER_PARITY_EN
                DONE, ERR: begin
`else
                DONE: begin
`endif
                    // A start bit may follow the stop bit immediately.
                    if (!bus.in) begin
                        r_state <= DATA;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
`ifdef SERIAL_DESER_PARITY_EN
                        r_par   <= 1'b0;
`endif
                    end else begin
                        r_state <= IDLE;
                    end
                end
                WAIT: begin
                    if (bus.in) r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.out_byte  = r_out;
    assign bus.done      = r_done;
    assign bus.frame_err = r_err;
    assign bus.busy      = r_busy;
endmodule
